alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_sequencer.sv | 94 +++++++++
 tb/tb_alu_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer and the ALU bench: opcode encoding,
// sequencer FSM states and the width of the completed-response counter.
package alu_seq_pkg;

  localparam int OPCNT_W = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_NOT = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } seq_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_SHR);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Issues one command at a time to an external combinational ALU and returns the result.
// Optional macro ALU_SEQUENCER_DIVZERO_CHECK_EN flags divide-by-zero as an error.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [N-1:0]       cmd_a,
  input  logic [N-1:0]       cmd_b,
  input  logic               cmd_sign,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [3:0]         alu_operation,
  output logic               alu_sign,
  input  logic [N-1:0]       alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_result,
  output logic               rsp_err,
  output logic [OPCNT_W-1:0] op_count
);

  seq_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_DRIVE;
      end
      S_DRIVE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // alu_* only change on command acceptance, so they hold between commands
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      alu_sign      <= 1'b0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
      rsp_valid     <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          alu_a         <= cmd_a;
          alu_b         <= cmd_b;
          alu_operation <= cmd_op;
          alu_sign      <= cmd_sign;
        end
        S_DRIVE: begin
          rsp_valid <= 1'b1;
          if (!op_legal(alu_operation)) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
`ifdef ALU_SEQUENCER_DIVZERO_CHECK_EN
          else if (alu_operation == 4'(OP_DIV) && alu_b == '0) begin
            rsp_result <= '1;
            rsp_err    <= 1'b1;
          end
`endif
          else begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          if (op_count != '1) op_count <= op_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model wired beside it.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_sign;
  logic [3:0]   cmd_op;
  logic [N-1:0] cmd_a, cmd_b;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_operation;
  logic         alu_sign;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [N-1:0] rsp_result;
  logic [15:0]  op_count;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sign(cmd_sign),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .alu_sign(alu_sign),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  // External ALU; divide by zero yields a recognisable 8'hEE
  always_comb begin
    alu_result = 8'h5A;
    case (alu_operation)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a * alu_b;
      4'd3: begin
        if (alu_b == 8'h00)  alu_result = 8'hEE;
        else if (alu_sign)   alu_result = $signed(alu_a) / $signed(alu_b);
        else                 alu_result = alu_a / alu_b;
      end
      4'd4: alu_result = alu_a & alu_b;
      4'd5: alu_result = alu_a | alu_b;
      4'd6: alu_result = ~alu_a;
      4'd7: alu_result = alu_a << alu_b;
      4'd8: alu_result = alu_a >> alu_b;
      default: alu_result = 8'h5A;
    endcase
  end

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       sign;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[13];
  int total = 0;
  int bad = 0;
  logic [15:0] exp_count;
  logic [7:0]  held;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_sign = v.sign;
    @(negedge clk);                                    // edge T done
    cmd_valid = 1'b0;
    chk({v.name, "_t1_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({v.name, "_alu_a"}, {24'd0, alu_a}, {24'd0, v.a});
    chk({v.name, "_alu_op"}, {28'd0, alu_operation}, {28'd0, v.op});
    @(negedge clk);                                    // T+2 cycle
    chk({v.name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({v.name, "_result"}, {24'd0, rsp_result}, {24'd0, v.res});
    chk({v.name, "_err"}, {31'd0, rsp_err}, {31'd0, v.err});
    @(negedge clk);                                    // handshake done
    exp_count = exp_count + 16'd1;
    chk({v.name, "_count"}, {16'd0, op_count}, {16'd0, exp_count});
    chk({v.name, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({v.name, "_idle_hold"}, {24'd0, alu_b}, {24'd0, v.b});
  endtask

  initial begin
    vecs[0]  = '{"add",    4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[1]  = '{"sub",    4'd1,  8'h10, 8'h20, 1'b0, 8'hF0, 1'b0};
    vecs[2]  = '{"mul",    4'd2,  8'h0F, 8'h11, 1'b0, 8'hFF, 1'b0};
    vecs[3]  = '{"sdiv",   4'd3,  8'hF6, 8'h03, 1'b1, 8'hFD, 1'b0};
    vecs[4]  = '{"udiv",   4'd3,  8'hF6, 8'h03, 1'b0, 8'h52, 1'b0};
    vecs[5]  = '{"and",    4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vecs[6]  = '{"or",     4'd5,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{"not",    4'd6,  8'hA5, 8'h00, 1'b0, 8'h5A, 1'b0};
    vecs[8]  = '{"shl",    4'd7,  8'h81, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[9]  = '{"shr",    4'd8,  8'h81, 8'h04, 1'b0, 8'h08, 1'b0};
    vecs[10] = '{"ill_a",  4'hA,  8'h12, 8'h34, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{"ill_f",  4'hF,  8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1};
`ifdef ALU_SEQUENCER_DIVZERO_CHECK_EN
    vecs[12] = '{"divz",   4'd3,  8'h40, 8'h00, 1'b0, 8'hFF, 1'b1};
`else
    vecs[12] = '{"divz",   4'd3,  8'h40, 8'h00, 1'b0, 8'hEE, 1'b0};
`endif

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_sign = 1'b0; rsp_ready = 1'b1; exp_count = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_count", {16'd0, op_count}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Backpressure: response must hold while new commands are refused
    wait_ready();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h21; cmd_b = 8'h12; cmd_sign = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmd_op = 4'd1; cmd_a = 8'hCC; cmd_b = 8'h11;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", {24'd0, rsp_result}, 32'h33);
      chk("bp_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_alu_a", {24'd0, alu_a}, 32'h21);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    chk("bp_count", {16'd0, op_count}, {16'd0, exp_count});
    chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_no_second", {24'd0, alu_a}, 32'h21);

    // Reset while in DRIVE drops the command
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h05; cmd_b = 8'h06;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 16'd0;
    chk("rd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rd_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rd_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rd_result", {24'd0, rsp_result}, 32'd0);
    chk("rd_count", {16'd0, op_count}, 32'd0);
    held = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      held = held | {7'd0, rsp_valid};
    end
    chk("rd_no_rsp", {24'd0, held}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
